// File: rtl/mux_arb_nxw_pkg.sv
// Shared definitions for the N-channel, W-bit selector/arbiter.
//   MUX_MODE_ADDR / MUX_MODE_RR : encodings of the mode input.
//   wrap_inc                    : index + 1 modulo n. Used for the round-robin pointer.
package mux_arb_nxw_pkg;

  localparam logic MUX_MODE_ADDR = 1'b0;
  localparam logic MUX_MODE_RR   = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_arb_nxw_rr_pick.sv
// Combinational rotating-priority encoder.
//   req     : per-channel request bits
//   ptr     : highest-priority channel this cycle (always < CHANNELS)
//   gnt_idx : first requesting channel, scanning ptr, ptr+1, ... with wrap
//   gnt_any : high when any channel requests
module mux_arb_nxw_rr_pick #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  always_comb begin
    int k;
    k       = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      // ptr < CHANNELS, so a single subtraction is enough to wrap.
      k = int'(ptr) + i;
      if (k >= CHANNELS) k = k - CHANNELS;
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nxw.sv
// N-channel, W-bit selector with a one-deep registered output and valid/ready flow control.
//   clk, reset  : single clock; synchronous active-high reset
//   mode        : 0 = addressed (address picks the source), 1 = round-robin
//   address     : channel select in addressed mode
//   in_data     : flat input bus, channel k = in_data[k*WIDTH +: WIDTH]
//   in_valid    : per-channel valid
//   in_ready    : per-channel accept, one-hot or zero
//   out_data    : registered selected word
//   out_channel : channel that supplied out_data
//   out_valid   : out_data holds an unconsumed word
//   out_ready   : consumer accepts out_data this cycle
module mux_arb_nxw
  import mux_arb_nxw_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NSLOT = 1 << SEL_W;

  if (CHANNELS < 2 || CHANNELS > 16 || NSLOT < CHANNELS) begin : g_param_err
    $error("mux_arb_nxw: CHANNELS must be 2..16 and fit in SEL_W bits");
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en, xfer;
  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic             rr_any, gnt_any;
  logic [NSLOT-1:0] valid_ext;
  logic [WIDTH-1:0] sel_data;

  mux_arb_nxw_rr_pick #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Padded to the full address range so an out-of-range address indexes a zero.
  assign valid_ext = NSLOT'(in_valid);

  assign load_en = !vld_q || out_ready;

  always_comb begin
    if (mode == MUX_MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt_idx = address;
      gnt_any = (int'(address) < CHANNELS) && valid_ext[address];
    end
  end

  // Grant implies the granted channel is valid, so ready alone marks a transfer.
  assign xfer = !reset && load_en && gnt_any;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        in_ready[k] = xfer;
        sel_data    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d = data_q;
    chan_d = chan_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      data_d = sel_data;
      chan_d = gnt_idx;
      vld_d  = 1'b1;
      if (mode == MUX_MODE_RR) ptr_d = SEL_W'(wrap_inc(int'(gnt_idx), CHANNELS));
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_data    = data_q;
  assign out_channel = chan_q;
  assign out_valid   = vld_q;

endmodule

// File: tb/tb_mux_arb_nxw.sv
module tb_mux_arb_nxw;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [2:0]  address;
  logic [63:0] in_data;
  logic [7:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_channel;
  logic        out_valid, out_ready;

  // 10-channel instance for the out-of-range address cases.
  logic        r_mode;
  logic [3:0]  r_address;
  logic [79:0] r_in_data;
  logic [9:0]  r_in_valid, r_in_ready;
  logic [7:0]  r_out_data;
  logic [3:0]  r_out_channel;
  logic        r_out_valid, r_out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int         m_vld, m_ch, m_ptr;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .address(address),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(10), .SEL_W(4)) dut10 (
    .clk(clk), .reset(reset), .mode(r_mode), .address(r_address),
    .in_data(r_in_data), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .out_data(r_out_data), .out_channel(r_out_channel), .out_valid(r_out_valid),
    .out_ready(r_out_ready)
  );

  // Channel the specification's rules would grant right now, -1 for none.
  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(address) < 8 && in_valid[address]) return int'(address);
      return -1;
    end
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (m_ptr + i) % 8;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_ready();
    int g;
    logic [7:0] r;
    g = model_grant();
    r = 8'h00;
    if (!reset && (m_vld == 0 || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and step the model with the inputs that were applied.
  task automatic tick();
    int   g;
    logic le, rst, md, ordy;
    logic [63:0] d;
    g    = model_grant();
    le   = (m_vld == 0) || out_ready;
    rst  = reset;
    md   = mode;
    ordy = out_ready;
    d    = in_data;
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
    end else if (le && g >= 0) begin
      m_vld  = 1;
      m_data = d[g*8 +: 8];
      m_ch   = g;
      if (md) m_ptr = (g + 1) % 8;
    end else if (m_vld != 0 && ordy) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = {$urandom, $urandom};
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 8'h00) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %h want 00", i, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_channel !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got v=%b d=%h c=%0d want v=0 d=00 c=0", i, out_valid, out_data, out_channel);
      end
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 8'h01) begin
      n_fail++; $display("FAIL reset_ptr0: got %h want 01", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_channel !== 3'd0 || out_data !== m_data) begin
      n_fail++;
      $display("FAIL reset_first_word: got v=%b c=%0d d=%h want v=1 c=0 d=%h", out_valid, out_channel, out_data, m_data);
    end
  endtask

  task automatic test_addressed();
    do_reset();
    mode = 1'b0; address = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    in_data = {$urandom, $urandom};
    in_data[47:40] = 8'hA5;
    #1;
    n_tests++;
    if (in_ready !== 8'h20 || in_ready !== model_ready()) begin
      n_fail++; $display("FAIL addr_in_ready: got %h want 20", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_channel !== 3'd5) begin
      n_fail++;
      $display("FAIL addr_out: got v=%b d=%h c=%0d want v=1 d=a5 c=5", out_valid, out_data, out_channel);
    end
    // Addressed channel not valid: no grant, held word is consumed.
    address = 3'd7; in_valid = 8'h7F; in_data = {$urandom, $urandom};
    #1;
    n_tests++;
    if (in_ready !== 8'h00) begin
      n_fail++; $display("FAIL addr_invalid_ch: got %h want 00", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_channel !== 3'd5) begin
      n_fail++;
      $display("FAIL addr_consume: got v=%b d=%h c=%0d want v=0 d=a5 c=5", out_valid, out_data, out_channel);
    end
    in_valid = 8'h00;
    // CHANNELS=10 instance.
    r_mode = 1'b0; r_out_ready = 1'b1; r_in_data = {$urandom, $urandom, 16'h0};
    r_address = 4'd9; r_in_valid = 10'h1FF;
    #1;
    n_tests++;
    if (r_in_ready !== 10'h000) begin
      n_fail++; $display("FAIL addr9_not_valid: got %h want 000", r_in_ready);
    end
    r_address = 4'd12; r_in_valid = 10'h3FF;
    #1;
    n_tests++;
    if (r_in_ready !== 10'h000) begin
      n_fail++; $display("FAIL addr12_out_of_range: got %h want 000", r_in_ready);
    end
    r_address = 4'd9;
    #1;
    n_tests++;
    if (r_in_ready !== 10'h200) begin
      n_fail++; $display("FAIL addr9_valid: got %h want 200", r_in_ready);
    end
    r_in_valid = 10'h000;
  endtask

  task automatic test_rr_fairness();
    int exp_seq[6] = '{0, 2, 7, 0, 2, 7};
    logic [7:0] want;
    do_reset();
    mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = {$urandom, $urandom};
      want = 8'h00;
      want[exp_seq[i]] = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== want || in_ready !== model_ready()) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %h want %h", i, in_ready, want);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_channel !== 3'(exp_seq[i]) || out_data !== m_data) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", i, out_valid, out_channel, out_data, exp_seq[i], m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    do_reset();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = {$urandom, $urandom};
    held = in_data[7:0];
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom};
      #1;
      n_tests++;
      if (in_ready !== 8'h00) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %h want 00", i, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== held || out_channel !== 3'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=0", i, out_valid, out_data, out_channel, held);
      end
    end
    out_ready = 1'b1; in_data = {$urandom, $urandom};
    #1;
    n_tests++;
    if (in_ready !== 8'h02) begin
      n_fail++; $display("FAIL bp_release_ready: got %h want 02", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_channel !== 3'd1 || out_data !== in_data[15:8]) begin
      n_fail++;
      $display("FAIL bp_no_bubble: got v=%b c=%0d d=%h want v=1 c=1 d=%h", out_valid, out_channel, out_data, in_data[15:8]);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 8'h08; out_ready = 1'b1; in_data = {$urandom, $urandom};
    tick();
    n_tests++;
    if (out_channel !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ms_rr_ch3: got c=%0d v=%b want c=3 v=1", out_channel, out_valid);
    end
    mode = 1'b0; address = 3'd1; in_valid = 8'h0A;
    #1;
    n_tests++;
    if (in_ready !== 8'h02) begin
      n_fail++; $display("FAIL ms_addr_ready: got %h want 02", in_ready);
    end
    tick();
    n_tests++;
    if (out_channel !== 3'd1 || out_data !== in_data[15:8]) begin
      n_fail++; $display("FAIL ms_addr_out: got c=%0d d=%h want c=1 d=%h", out_channel, out_data, in_data[15:8]);
    end
    mode = 1'b1; in_valid = 8'h18;
    #1;
    n_tests++;
    if (in_ready !== 8'h10 || in_ready !== model_ready()) begin
      n_fail++; $display("FAIL ms_rr_ptr_kept: got %h want 10", in_ready);
    end
    tick();
    n_tests++;
    if (out_channel !== 3'd4) begin
      n_fail++; $display("FAIL ms_rr_ch4: got %0d want 4", out_channel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; in_valid = 8'h02; out_ready = 1'b1; in_data = {$urandom, $urandom};
    tick();                                   // ptr moves to 2
    mode = 1'b0; address = 3'd2; in_valid = 8'h04; in_data = 64'h0000_0000_003C_0000;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++; $display("FAIL rm_loaded: got v=%b d=%h want v=1 d=3c", out_valid, out_data);
    end
    out_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_channel !== 3'd0) begin
      n_fail++;
      $display("FAIL rm_cleared: got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_channel);
    end
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 8'h01) begin
      n_fail++; $display("FAIL rm_ptr0: got %h want 01", in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom);
      address   = 3'($urandom);
      in_valid  = 8'($urandom) & 8'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (in_ready !== model_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %h want %h", i, in_ready, model_ready());
      end
      tick();
      n_tests++;
      if (out_valid !== 1'(m_vld) || out_data !== m_data || out_channel !== 3'(m_ch)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d want v=%0d d=%h c=%0d", i, out_valid, out_data, out_channel, m_vld, m_data, m_ch);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_vld = 0; m_ch = 0; m_ptr = 0; m_data = 8'h00;
    reset = 1'b1; mode = 1'b0; address = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    r_mode = 1'b0; r_address = '0; r_in_data = '0; r_in_valid = '0; r_out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_addressed();
    test_rr_fairness();
    test_backpressure();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
